// File: rtl/riscv_alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: FSM state encoding and default field widths.
package riscv_alu_issue_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

    localparam int LAT_W_DEF  = 5;
    localparam int PERF_W_DEF = 32;

endpackage

// File: rtl/riscv_alu_lat_counter.sv
// Loadable latency down-counter; o_term flags the last cycle of a multi-cycle op (count==1).
module riscv_alu_lat_counter #(
    parameter int LAT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [LAT_W-1:0] i_load_val,
    input  logic             i_clear,
    output logic             o_term
);

    logic [LAT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - LAT_W'(1);
        end
    end

    assign o_term = (r_count == LAT_W'(1));

endmodule

// File: rtl/riscv_alu_issue_ctrl.sv
// ALU issue controller: accepts ops from decode, stalls the front-end for multi-cycle ops,
// and produces a one-cycle writeback strobe with rd/data.
module riscv_alu_issue_ctrl
    import riscv_alu_issue_ctrl_pkg::*;
#(
    parameter int LAT_W  = LAT_W_DEF,
    parameter int PERF_W = PERF_W_DEF
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              issue_valid_i,
    output logic              issue_ready_o,
    input  logic [4:0]        issue_rd_i,
    input  logic [LAT_W-1:0]  issue_latency_i,
    input  logic              flush_i,
    input  logic [31:0]       alu_result_i,
    output logic              alu_hold_o,
    output logic              stall_o,
    output logic              busy_o,
    output logic [4:0]        busy_rd_o,
    output logic              wb_valid_o,
    output logic [4:0]        wb_rd_o,
    output logic [31:0]       wb_data_o,
    output logic [PERF_W-1:0] perf_stall_cnt_o
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [4:0]        r_busy_rd;
    logic [PERF_W-1:0] r_perf_cnt;
    logic              w_in_exec;
    logic              w_accept;
    logic              w_load;
    logic              w_term;
    logic              w_complete;

    assign w_in_exec  = (r_state == ST_EXEC);
    assign w_accept   = issue_valid_i & issue_ready_o & ~flush_i;
    assign w_load     = w_accept & (issue_latency_i != '0);
    // Flush outranks completion when both land on the counter==1 cycle.
    assign w_complete = w_in_exec & w_term & ~flush_i;

    riscv_alu_lat_counter #(
        .LAT_W(LAT_W)
    ) u_lat_counter (
        .i_clk      (clock_i),
        .i_rst      (reset_i),
        .i_load     (w_load),
        .i_load_val (issue_latency_i),
        .i_clear    (w_in_exec & flush_i),
        .o_term     (w_term)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: next-state defaults to the current state first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_load)            w_state_nxt = ST_EXEC;
            ST_EXEC: if (flush_i || w_term) w_state_nxt = ST_IDLE;
            default:                        w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_busy_rd <= '0;
        end else if (w_load) begin
            r_busy_rd <= issue_rd_i;
        end
    end

    // rd=0 ops never strobe, and wb_rd/wb_data only move when a strobe is produced.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wb_valid_o <= 1'b0;
            wb_rd_o    <= '0;
            wb_data_o  <= '0;
        end else begin
            wb_valid_o <= 1'b0;
            if (w_accept && (issue_latency_i == '0) && (issue_rd_i != '0)) begin
                wb_valid_o <= 1'b1;
                wb_rd_o    <= issue_rd_i;
                wb_data_o  <= alu_result_i;
            end else if (w_complete && (r_busy_rd != '0)) begin
                wb_valid_o <= 1'b1;
                wb_rd_o    <= r_busy_rd;
                wb_data_o  <= alu_result_i;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_perf_cnt <= '0;
        end else if (stall_o && (r_perf_cnt != '1)) begin
            r_perf_cnt <= r_perf_cnt + PERF_W'(1);
        end
    end

    assign issue_ready_o    = ~w_in_exec;
    assign alu_hold_o       = w_in_exec;
    assign stall_o          = w_in_exec;
    assign busy_o           = w_in_exec;
    assign busy_rd_o        = w_in_exec ? r_busy_rd : 5'd0;
    assign perf_stall_cnt_o = r_perf_cnt;

endmodule
